game_screen_sequencer: RTL and testbench
========================================

# game_screen_sequencer

Screen sequencer for the 96x64 RGB565 OLED path. Sits between the OLED driver and the per-screen pixel generators (`Game_Screen_0..3`-style blocks). It decodes the driver's `pixel_index` into `x`/`y` for the screen generators and selects which generator drives `oled_data`. Screen changes come from button requests or an auto-advance timer and are committed only at frame boundaries, with an optional black blanking interval between screens.

## Interface
Parameters:
- `BLANK_FRAMES`, default 2: number of full black frames between screens; 0 means switch directly.
- `AUTO_FRAMES`, default 0: frames per screen before an automatic "next" request; 0 disables auto-advance.

Ports:
- `clk`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `frame_begin`  in  1: single-cycle pulse from the OLED driver at the start of each frame.
- `pixel_index`  in  13: driver pixel address, valid range 0..6143, row-major.
- `btn_next`  in  1: single-cycle, already-debounced request to go to the next screen.
- `btn_prev`  in  1: single-cycle, already-debounced request to go to the previous screen.
- `screen0_data` .. `screen3_data`  in  16 each: RGB565 pixel from each screen generator for the current `x`/`y`.
- `x`  out  7: column, 0..95.
- `y`  out  6: row, 0..63.
- `oled_data`  out  16: registered pixel to the OLED driver.
- `screen_id`  out  2: currently displayed screen.
- `busy`  out  1: high while a screen change is pending or blanking.

## Operation
- Coordinate decode is combinational:
  - `x = pixel_index % 96`, `y = pixel_index / 96`.
  - For `pixel_index >= 6144`: `x=0`, `y=0`, and the pixel is forced to black (16'h0000).
- Pixel select: in SHOW, the pixel is `screenN_data` with `N = screen_id`. In WAIT_FRAME the current screen keeps being shown. In BLANK the pixel is 16'h0000.
- Requests:
  - `btn_next` and `btn_prev` high in the same cycle: the request is discarded.
  - Requests are accepted only in SHOW. Requests arriving while `busy` are dropped, not queued.
- Target computation (2-bit wrap): next is `screen_id+1` (3 wraps to 0); prev is `screen_id-1` (0 wraps to 3). The target is latched at acceptance.
- FSM states:
  - SHOW: on an accepted request, latch the target and go to WAIT_FRAME.
  - WAIT_FRAME: on `frame_begin`:
    - if `BLANK_FRAMES==0`, set `screen_id<=target` and go to SHOW;
    - otherwise clear `blank_cnt` and go to BLANK.
  - BLANK: each `frame_begin` increments `blank_cnt`. On the `frame_begin` where `blank_cnt == BLANK_FRAMES-1`, set `screen_id<=target` and go to SHOW. The result is exactly `BLANK_FRAMES` complete black frames.
- Auto-advance (`AUTO_FRAMES>0`):
  - `auto_cnt` counts `frame_begin` pulses in SHOW.
  - When the count reaches `AUTO_FRAMES`, an internal "next" request is accepted as if from `btn_next`.
  - A button request in the same cycle takes priority over the auto request.
  - `auto_cnt` clears on every `screen_id` change and on any accepted request.
- `busy` is 1 in WAIT_FRAME and BLANK, 0 in SHOW.
- Counters are sized to hold their parameter value; no overflow in legal ranges.

## Timing
- Reset values: state=SHOW, `screen_id`=0, `oled_data`=16'h0000, `busy`=0, `blank_cnt`=0, `auto_cnt`=0, target=0.
- `x`/`y`: zero latency from `pixel_index`.
- `oled_data`: one-cycle latency. The value registered at edge k reflects `pixel_index`, state and `screen_id` as sampled at edge k.
- An accepted request at edge k makes `busy` high from edge k.
- A `frame_begin` sampled at edge k causes the state/`screen_id` update at edge k. `oled_data` reflects the change from edge k+1.
- `reset` mid-transition: the next edge returns to SHOW with screen 0, abandons any pending target, and makes `oled_data` 0.
- `frame_begin` coinciding with an accepted request in SHOW: the request moves to WAIT_FRAME only; that `frame_begin` is not used for the commit.

## Test plan
1. Reset and pass-through:
   - Hold `reset` 3 cycles → `oled_data`=0000, `screen_id`=0, `busy`=0.
   - Release; `screen0_data`=07E0, `pixel_index`=0 → `oled_data`=07E0 one cycle later.
2. Decode:
   - `pixel_index`=97 → x=1, y=1.
   - 6143 → x=95, y=63.
   - 6144 → x=0, y=0, `oled_data`=0000 next cycle.
3. Blanked change (`BLANK_FRAMES`=2; `screen1_data`=F800):
   - Pulse `btn_next` → `busy`=1 and screen 0 still shown.
   - 1st `frame_begin` → `oled_data`=0000.
   - 3rd `frame_begin` → `screen_id`=1, `busy`=0, `oled_data`=F800.
4. Wrap and direct switch (`BLANK_FRAMES`=0):
   - `btn_prev` from screen 0 → `screen_id`=3 at the next `frame_begin`.
   - `btn_next` from 3 → 0.
5. Drops:
   - `btn_next`+`btn_prev` in the same cycle → `busy` stays 0, `screen_id` unchanged.
   - `btn_next` during BLANK → the final `screen_id` is still the first target.
   - `reset` during BLANK → `screen_id`=0, SHOW on the next edge.
6. Auto-advance (`AUTO_FRAMES`=3, `BLANK_FRAMES`=0): 3 `frame_begin` pulses in SHOW → request accepted; the 4th `frame_begin` commits `screen_id`=1; the cycle repeats to 2.

Source files
------------

// File: rtl/game_screen_sequencer_if.sv
// Bundle between the OLED driver / screen generators and the screen sequencer.
// master drives frame timing, buttons and generator pixels; slave is the sequencer.
interface game_screen_sequencer_if;
   logic        frame_begin;
   logic [12:0] pixel_index;
   logic        btn_next;
   logic        btn_prev;
   logic [15:0] screen0_data;
   logic [15:0] screen1_data;
   logic [15:0] screen2_data;
   logic [15:0] screen3_data;
   logic [6:0]  x;
   logic [5:0]  y;
   logic [15:0] oled_data;
   logic [1:0]  screen_id;
   logic        busy;

   modport master (
      output frame_begin, pixel_index, btn_next, btn_prev,
      output screen0_data, screen1_data, screen2_data, screen3_data,
      input  x, y, oled_data, screen_id, busy
   );

   modport slave (
      input  frame_begin, pixel_index, btn_next, btn_prev,
      input  screen0_data, screen1_data, screen2_data, screen3_data,
      output x, y, oled_data, screen_id, busy
   );
endinterface

// File: rtl/game_screen_sequencer.sv
// Selects one of four screen generators for a 96x64 RGB565 OLED, decoding pixel_index
// into x/y and committing screen changes only on frame boundaries with optional blanking.
module game_screen_sequencer #(
   parameter int unsigned BLANK_FRAMES = 2,
   parameter int unsigned AUTO_FRAMES  = 0
) (
   input logic                    clk,
   input logic                    reset,
   game_screen_sequencer_if.slave bus
);

   localparam int unsigned BlankW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
   localparam int unsigned AutoW  = (AUTO_FRAMES > 0) ? $clog2(AUTO_FRAMES + 1) : 1;
   localparam logic [BlankW-1:0] BlankLast =
      BlankW'((BLANK_FRAMES == 0) ? 0 : BLANK_FRAMES - 1);
   localparam logic [AutoW-1:0] AutoLast =
      AutoW'((AUTO_FRAMES == 0) ? 0 : AUTO_FRAMES - 1);

   typedef enum logic [1:0] {
      StShow,
      StWaitFrame,
      StBlank
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        screen_id_q, screen_id_d;
   logic [1:0]        target_q, target_d;
   logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;
   logic [AutoW-1:0]  auto_cnt_q, auto_cnt_d;
   logic [15:0]       oled_data_q, pixel_d;

   // Coordinate decode
   logic        in_range;
   logic [12:0] y_full;
   logic [12:0] x_full;
   logic        unused_div;

   assign in_range   = bus.pixel_index < 13'd6144;
   assign y_full     = bus.pixel_index / 13'd96;
   assign x_full     = bus.pixel_index - (y_full * 13'd96);
   assign unused_div = ^{y_full[12:6], x_full[12:7]};

   assign bus.x = in_range ? x_full[6:0] : 7'd0;
   assign bus.y = in_range ? y_full[5:0] : 6'd0;

   // Request arbitration: simultaneous buttons cancel, a lone button beats auto-advance.
   logic btn_req;
   logic auto_hit;
   logic req_valid;
   logic req_next;

   assign btn_req   = bus.btn_next ^ bus.btn_prev;
   assign auto_hit  = (AUTO_FRAMES != 0) && bus.frame_begin && (auto_cnt_q == AutoLast);
   assign req_valid = btn_req | auto_hit;
   assign req_next  = btn_req ? bus.btn_next : 1'b1;

   always_comb begin
      state_d     = state_q;
      screen_id_d = screen_id_q;
      target_d    = target_q;
      blank_cnt_d = blank_cnt_q;
      auto_cnt_d  = auto_cnt_q;

      unique case (state_q)
         StShow: begin
            if (req_valid) begin
               target_d   = req_next ? screen_id_q + 2'd1 : screen_id_q - 2'd1;
               auto_cnt_d = '0;
               state_d    = StWaitFrame;
            end else if (bus.frame_begin && (AUTO_FRAMES != 0)) begin
               auto_cnt_d = auto_cnt_q + 1'b1;
            end
         end
         StWaitFrame: begin
            if (bus.frame_begin) begin
               if (BLANK_FRAMES == 0) begin
                  screen_id_d = target_q;
                  auto_cnt_d  = '0;
                  state_d     = StShow;
               end else begin
                  blank_cnt_d = '0;
                  state_d     = StBlank;
               end
            end
         end
         StBlank: begin
            if (bus.frame_begin) begin
               if (blank_cnt_q == BlankLast) begin
                  screen_id_d = target_q;
                  auto_cnt_d  = '0;
                  state_d     = StShow;
               end else begin
                  blank_cnt_d = blank_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StShow;
      endcase
   end

   // Pixel reflects state and screen_id as they stand before this edge's update.
   always_comb begin
      pixel_d = 16'h0000;
      unique case (screen_id_q)
         2'd0: pixel_d = bus.screen0_data;
         2'd1: pixel_d = bus.screen1_data;
         2'd2: pixel_d = bus.screen2_data;
         2'd3: pixel_d = bus.screen3_data;
         default: pixel_d = 16'h0000;
      endcase
      if ((state_q == StBlank) || !in_range) begin
         pixel_d = 16'h0000;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StShow;
         screen_id_q <= 2'd0;
         target_q    <= 2'd0;
         blank_cnt_q <= '0;
         auto_cnt_q  <= '0;
         oled_data_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         screen_id_q <= screen_id_d;
         target_q    <= target_d;
         blank_cnt_q <= blank_cnt_d;
         auto_cnt_q  <= auto_cnt_d;
         oled_data_q <= pixel_d;
      end
   end

   assign bus.oled_data = oled_data_q;
   assign bus.screen_id = screen_id_q;
   assign bus.busy      = (state_q != StShow);

endmodule

// File: tb/tb_game_screen_sequencer.sv
// Bench for game_screen_sequencer: three instances (blanked, direct, auto-advance) share
// one stimulus; registered pixels are checked through an expected-value queue.
module tb_game_screen_sequencer;

   logic        clk;
   logic        reset;
   logic        frame_begin;
   logic [12:0] pixel_index;
   logic        btn_next;
   logic        btn_prev;

   localparam logic [15:0] S0 = 16'h07E0;
   localparam logic [15:0] S1 = 16'hF800;
   localparam logic [15:0] S2 = 16'h001F;
   localparam logic [15:0] S3 = 16'hFFFF;

   game_screen_sequencer_if bus0 ();
   game_screen_sequencer_if bus1 ();
   game_screen_sequencer_if bus2 ();

   game_screen_sequencer #(.BLANK_FRAMES(2), .AUTO_FRAMES(0)) u_blank (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );
   game_screen_sequencer #(.BLANK_FRAMES(0), .AUTO_FRAMES(0)) u_direct (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );
   game_screen_sequencer #(.BLANK_FRAMES(0), .AUTO_FRAMES(3)) u_auto (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   assign bus0.frame_begin = frame_begin;   assign bus1.frame_begin = frame_begin;
   assign bus2.frame_begin = frame_begin;
   assign bus0.pixel_index = pixel_index;   assign bus1.pixel_index = pixel_index;
   assign bus2.pixel_index = pixel_index;
   assign bus0.btn_next = btn_next;         assign bus1.btn_next = btn_next;
   assign bus2.btn_next = btn_next;
   assign bus0.btn_prev = btn_prev;         assign bus1.btn_prev = btn_prev;
   assign bus2.btn_prev = btn_prev;
   assign bus0.screen0_data = S0;  assign bus1.screen0_data = S0;  assign bus2.screen0_data = S0;
   assign bus0.screen1_data = S1;  assign bus1.screen1_data = S1;  assign bus2.screen1_data = S1;
   assign bus0.screen2_data = S2;  assign bus1.screen2_data = S2;  assign bus2.screen2_data = S2;
   assign bus0.screen3_data = S3;  assign bus1.screen3_data = S3;  assign bus2.screen3_data = S3;

   logic [15:0] oled [3];
   logic [1:0]  sid  [3];
   logic        busy [3];
   logic [6:0]  xo;
   logic [5:0]  yo;

   assign oled[0] = bus0.oled_data;  assign sid[0] = bus0.screen_id;  assign busy[0] = bus0.busy;
   assign oled[1] = bus1.oled_data;  assign sid[1] = bus1.screen_id;  assign busy[1] = bus1.busy;
   assign oled[2] = bus2.oled_data;  assign sid[2] = bus2.screen_id;  assign busy[2] = bus2.busy;
   assign xo = bus0.x;
   assign yo = bus0.y;

   typedef struct {
      int          dut;
      logic [15:0] exp;
      string       tag;
   } sb_entry_t;

   sb_entry_t sb_q [$];
   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then compare every pixel expectation queued before it.
   task automatic tick();
      sb_entry_t e;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_eq(e.tag, {16'h0, oled[e.dut]}, {16'h0, e.exp});
      end
   endtask

   task automatic expect_pix(input int dut, input logic [15:0] exp, input string tag);
      sb_entry_t e;
      e.dut = dut;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
      tick();
   endtask

   task automatic pulse_frame();
      frame_begin = 1'b1;
      tick();
      frame_begin = 1'b0;
      tick();
   endtask

   task automatic press(input logic nxt, input logic prv);
      btn_next = nxt;
      btn_prev = prv;
      tick();
      btn_next = 1'b0;
      btn_prev = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      frame_begin = 1'b0;
      pixel_index = 13'd0;
      btn_next    = 1'b0;
      btn_prev    = 1'b0;

      // Reset and pass-through
      repeat (3) tick();
      for (int i = 0; i < 3; i++) begin
         check_eq("rst_oled", {16'h0, oled[i]}, 32'h0);
         check_eq("rst_sid", {30'h0, sid[i]}, 32'h0);
         check_eq("rst_busy", {31'h0, busy[i]}, 32'h0);
      end
      reset = 1'b0;
      expect_pix(0, S0, "pass_s0");

      // Decode
      pixel_index = 13'd97;
      #1;
      check_eq("dec97_x", {25'h0, xo}, 32'd1);
      check_eq("dec97_y", {26'h0, yo}, 32'd1);
      pixel_index = 13'd6143;
      #1;
      check_eq("dec6143_x", {25'h0, xo}, 32'd95);
      check_eq("dec6143_y", {26'h0, yo}, 32'd63);
      expect_pix(0, S0, "pix6143");
      pixel_index = 13'd6144;
      #1;
      check_eq("dec6144_x", {25'h0, xo}, 32'd0);
      check_eq("dec6144_y", {26'h0, yo}, 32'd0);
      expect_pix(0, 16'h0000, "pix6144_black");
      pixel_index = 13'd200;

      // Blanked change on the BLANK_FRAMES=2 instance
      do_reset();
      press(1'b1, 1'b0);
      check_eq("blk_busy_req", {31'h0, busy[0]}, 32'd1);
      check_eq("blk_sid_req", {30'h0, sid[0]}, 32'd0);
      expect_pix(0, S0, "blk_wait_show");
      pulse_frame();
      expect_pix(0, 16'h0000, "blk_frame1_black");
      pulse_frame();
      check_eq("blk_busy_f2", {31'h0, busy[0]}, 32'd1);
      expect_pix(0, 16'h0000, "blk_frame2_black");
      pulse_frame();
      check_eq("blk_sid_f3", {30'h0, sid[0]}, 32'd1);
      check_eq("blk_busy_f3", {31'h0, busy[0]}, 32'd0);
      expect_pix(0, S1, "blk_show_s1");

      // Wrap and direct switch on the BLANK_FRAMES=0 instance
      do_reset();
      press(1'b0, 1'b1);
      check_eq("dir_busy_prev", {31'h0, busy[1]}, 32'd1);
      pulse_frame();
      check_eq("dir_sid_wrap3", {30'h0, sid[1]}, 32'd3);
      check_eq("dir_busy_done", {31'h0, busy[1]}, 32'd0);
      expect_pix(1, S3, "dir_show_s3");
      press(1'b1, 1'b0);
      pulse_frame();
      check_eq("dir_sid_wrap0", {30'h0, sid[1]}, 32'd0);
      expect_pix(1, S0, "dir_show_s0");
      // Request and frame_begin together: that frame does not commit
      btn_next    = 1'b1;
      frame_begin = 1'b1;
      tick();
      btn_next    = 1'b0;
      frame_begin = 1'b0;
      check_eq("dir_coinc_busy", {31'h0, busy[1]}, 32'd1);
      check_eq("dir_coinc_sid", {30'h0, sid[1]}, 32'd0);
      pulse_frame();
      check_eq("dir_coinc_commit", {30'h0, sid[1]}, 32'd1);

      // Drops
      do_reset();
      press(1'b1, 1'b1);
      check_eq("both_busy", {31'h0, busy[0]}, 32'd0);
      pulse_frame();
      check_eq("both_sid", {30'h0, sid[0]}, 32'd0);
      press(1'b1, 1'b0);
      pulse_frame();
      press(1'b1, 1'b0);
      pulse_frame();
      press(1'b0, 1'b1);
      pulse_frame();
      check_eq("drop_sid", {30'h0, sid[0]}, 32'd1);
      check_eq("drop_busy", {31'h0, busy[0]}, 32'd0);
      press(1'b1, 1'b0);
      pulse_frame();
      check_eq("rstblk_busy_pre", {31'h0, busy[0]}, 32'd1);
      reset = 1'b1;
      tick();
      check_eq("rstblk_sid", {30'h0, sid[0]}, 32'd0);
      check_eq("rstblk_busy", {31'h0, busy[0]}, 32'd0);
      check_eq("rstblk_oled", {16'h0, oled[0]}, 32'h0);
      reset = 1'b0;
      expect_pix(0, S0, "rstblk_show_s0");
      repeat (3) pulse_frame();
      check_eq("rstblk_no_target", {30'h0, sid[0]}, 32'd0);

      // Auto-advance on the AUTO_FRAMES=3 instance
      do_reset();
      for (int s = 1; s <= 2; s++) begin
         pulse_frame();
         pulse_frame();
         check_eq("auto_idle_busy", {31'h0, busy[2]}, 32'd0);
         pulse_frame();
         tick();
         check_eq("auto_req_busy", {31'h0, busy[2]}, 32'd1);
         check_eq("auto_req_sid", {30'h0, sid[2]}, s - 1);
         pulse_frame();
         check_eq("auto_commit_sid", {30'h0, sid[2]}, s);
         check_eq("auto_commit_busy", {31'h0, busy[2]}, 32'd0);
      end
      expect_pix(2, S2, "auto_show_s2");
      // Button on the auto-hit frame wins over the auto "next"
      pulse_frame();
      pulse_frame();
      btn_prev    = 1'b1;
      frame_begin = 1'b1;
      tick();
      btn_prev    = 1'b0;
      frame_begin = 1'b0;
      pulse_frame();
      check_eq("auto_prio_sid", {30'h0, sid[2]}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
